uart_rx_ctrl: RTL

Receive-side controller sitting between the UART receiver shift register and the consumer logic. It watches the receiver's `data_ready`/`frame_error` outputs and sequences the `data_read_ack` handshake. Good frames go into a small show-ahead FIFO presented on a valid/ready port. Frame errors and overruns are counted for status readback.

---
 rtl/uart_rx_pkg.sv | 13 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_rx_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receive-control definitions: FSM encodings and default frame width.
// Encodings are common to the other UART control blocks, so keep them fixed.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_ACK     = 2'b10
    } rx_state_e;

    localparam int DEFAULT_DATA_SIZE = 7;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with extra-MSB pointers for full/empty detection.
// Latency: a push is visible on pop_dat/empty the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        // Head is forced to zero when empty so the output is clean out of reset.
        pop_dat  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        count    = wr_ptr_q - rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequences the UART receiver ack handshake, queues good frames, counts frame errors/overruns.
// Latency: frame visible on m_data two cycles after rx_data_ready is first sampled high.
// Backpressure: m_ready pops the FIFO; a good frame arriving while full with no pop is dropped.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_SIZE  = DEFAULT_DATA_SIZE,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_SIZE-1:0]        rx_data,
    input  logic                        rx_data_ready,
    input  logic                        rx_frame_error,
    output logic                        rx_data_read_ack,
    output logic [DATA_SIZE-1:0]        m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [CNT_W-1:0]            frame_err_cnt,
    output logic [CNT_W-1:0]            overrun_cnt,
    input  logic                        clear_counts
);

    rx_state_e        state_q, state_d;
    logic             ack_q, ack_d;
    logic [CNT_W-1:0] ferr_cnt_q, ferr_cnt_d;
    logic [CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;

    logic capture;
    logic pop;
    logic push;
    logic ferr_inc;
    logic ovr_inc;
    logic fifo_full;
    logic fifo_empty;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (rx_data_ready) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_ACK;
            ST_ACK:     if (!rx_data_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        ack_d = (state_d == ST_ACK);

        capture  = (state_q == ST_CAPTURE);
        pop      = m_valid && m_ready;
        ferr_inc = capture && rx_frame_error;
        // A pop in the capture cycle frees a slot, so a full FIFO still accepts the frame.
        push     = capture && !rx_frame_error && (!fifo_full || pop);
        ovr_inc  = capture && !rx_frame_error && fifo_full && !pop;

        if (clear_counts)                     ferr_cnt_d = '0;
        else if (ferr_inc && ~&ferr_cnt_q)    ferr_cnt_d = ferr_cnt_q + CNT_W'(1);
        else                                  ferr_cnt_d = ferr_cnt_q;

        if (clear_counts)                     ovr_cnt_d = '0;
        else if (ovr_inc && ~&ovr_cnt_q)      ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
        else                                  ovr_cnt_d = ovr_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            ferr_cnt_q <= '0;
            ovr_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            ferr_cnt_q <= ferr_cnt_d;
            ovr_cnt_q  <= ovr_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (rx_data),
        .pop      (pop),
        .pop_dat  (m_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign m_valid          = !fifo_empty;
    assign rx_data_read_ack = ack_q;
    assign frame_err_cnt    = ferr_cnt_q;
    assign overrun_cnt      = ovr_cnt_q;

endmodule
